// File: rtl/mdsa_phase_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdsa_phase_sequencer_pkg: shared states and helpers for shear-sort |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package mdsa_phase_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOAD   = 3'd1;
  localparam state_t S_ISSUE  = 3'd2;
  localparam state_t S_WAIT   = 3'd3;
  localparam state_t S_UNLOAD = 3'd4;
  localparam state_t S_FIN    = 3'd5;

  function automatic int lw_of(input int n);
    return $clog2(n);
  endfunction

  function automatic int aw_of(input int n);
    return 2 * $clog2(n);
  endfunction

  function automatic int nph_of(input int n);
    return 2 * $clog2(n) + 1;
  endfunction

  // Even phases sort rows, odd phases sort columns.
  function automatic logic phase_is_col(input int unsigned phase);
    return (phase % 2) != 0;
  endfunction

  function automatic int unsigned snake_addr(input int unsigned k, input int unsigned n);
    int unsigned r;
    int unsigned c;
    r = k / n;
    c = k % n;
    return r * n + (((r % 2) != 0) ? (n - 1 - c) : c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdsa_phase_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdsa_phase_sequencer_if: handshake, buffer and core-control bundle |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface mdsa_phase_sequencer_if #(
  parameter int N = 4
);
  localparam int LW  = $clog2(N);
  localparam int AW  = 2 * LW;
  localparam int NPH = 2 * LW + 1;
  localparam int PW  = $clog2(NPH);

  logic          start;
  logic          en;
  logic          rdy;
  logic          busy;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic          core_start;
  logic          core_is_col;
  logic          core_desc;
  logic [LW-1:0] core_line;
  logic          core_done;
  logic [PW-1:0] phase_idx;
  logic          output_enable;
  logic [AW-1:0] rd_addr;
  logic          done;

  modport slave (
    input  start, en, core_done,
    output rdy, busy, load_we, load_addr, core_start, core_is_col, core_desc,
           core_line, phase_idx, output_enable, rd_addr, done
  );

  modport master (
    output start, en, core_done,
    input  rdy, busy, load_we, load_addr, core_start, core_is_col, core_desc,
           core_line, phase_idx, output_enable, rd_addr, done
  );

endinterface
`default_nettype wire

// File: rtl/mdsa_phase_sequencer_snake_addr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdsa_snake_addr: unload index k to boustrophedon buffer address    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module mdsa_snake_addr #(
  parameter int N  = 4,
  parameter int AW = 2 * $clog2(N)
) (
  input  logic [AW-1:0] k_i,
  output logic [AW-1:0] addr_o
);
  import mdsa_phase_sequencer_pkg::*;

  assign addr_o = AW'(snake_addr(32'(k_i), N));

endmodule
`default_nettype wire

// File: rtl/mdsa_phase_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdsa_phase_sequencer: load / row-col phase issue / snake unload    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module mdsa_phase_sequencer #(
  parameter int N = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  mdsa_phase_sequencer_if.slave       bus_if
);
  import mdsa_phase_sequencer_pkg::*;

  localparam int LW  = lw_of(N);
  localparam int AW  = aw_of(N);
  localparam int NPH = nph_of(N);
  localparam int PW  = $clog2(NPH);

  localparam logic [AW-1:0] LAST_WORD  = AW'(N * N - 1);
  localparam logic [LW-1:0] LAST_LINE  = LW'(N - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(NPH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] load_addr_q, load_addr_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [LW-1:0] line_q, line_d;
  logic [PW-1:0] phase_q, phase_d;

  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    rd_cnt_d    = rd_cnt_q;
    line_d      = line_q;
    phase_d     = phase_q;
    case (state_q)
      S_IDLE: begin
        if (bus_if.start) begin
          state_d     = S_LOAD;
          load_addr_d = '0;
        end
      end
      S_LOAD: begin
        if (bus_if.en) begin
          load_addr_d = load_addr_q + 1'b1;
          if (load_addr_q == LAST_WORD) begin
            state_d = S_ISSUE;
            phase_d = '0;
            line_d  = '0;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // Lines advance within a phase first, then the phase advances.
        if (bus_if.core_done) begin
          if (line_q != LAST_LINE) begin
            line_d  = line_q + 1'b1;
            state_d = S_ISSUE;
          end else if (phase_q != LAST_PHASE) begin
            phase_d = phase_q + 1'b1;
            line_d  = '0;
            state_d = S_ISSUE;
          end else begin
            rd_cnt_d = '0;
            state_d  = S_UNLOAD;
          end
        end
      end
      S_UNLOAD: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST_WORD) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      load_addr_q <= '0;
      rd_cnt_q    <= '0;
      line_q      <= '0;
      phase_q     <= '0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      rd_cnt_q    <= rd_cnt_d;
      line_q      <= line_d;
      phase_q     <= phase_d;
    end
  end

  assign bus_if.rdy           = (state_q == S_IDLE);
  assign bus_if.busy          = (state_q != S_IDLE);
  assign bus_if.load_we       = bus_if.en & (state_q == S_LOAD);
  assign bus_if.load_addr     = load_addr_q;
  assign bus_if.core_start    = (state_q == S_ISSUE);
  assign bus_if.core_is_col   = phase_is_col(32'(phase_q));
  // Odd rows sort descending so the row-major result reads out as a snake.
  assign bus_if.core_desc     = ~phase_is_col(32'(phase_q)) & line_q[0];
  assign bus_if.core_line     = line_q;
  assign bus_if.phase_idx     = phase_q;
  assign bus_if.output_enable = (state_q == S_UNLOAD);
  assign bus_if.done          = (state_q == S_FIN);

  mdsa_snake_addr #(
    .N  (N),
    .AW (AW)
  ) u_snake_addr (
    .k_i    (rd_cnt_q),
    .addr_o (bus_if.rd_addr)
  );

endmodule
`default_nettype wire

// File: tb/tb_mdsa_phase_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mdsa_phase_sequencer: directed bench for the shear-sort sequencer |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_mdsa_phase_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdsa_phase_sequencer_if #(.N(4)) bus ();

  mdsa_phase_sequencer #(.N(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  logic model_done;
  logic force_done;
  bit   model_en;
  int   cd;
  assign bus.core_done = model_done | force_done;

  int total = 0;
  int bad   = 0;
  int ncyc = 0, start_cyc = 0, done_cyc = 0, oe_first = 0, oe_last = 0;
  int load_q[$];
  int core_q[$];
  int rd_q[$];
  int exp_rd[16] = '{0, 1, 2, 3, 7, 6, 5, 4, 8, 9, 10, 11, 15, 14, 13, 12};

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // {phase[2:0], is_col, desc, line[1:0]} for the i-th issued line
  function automatic int exp_core(input int i);
    int p, l, col, desc;
    p    = i / 4;
    l    = i % 4;
    col  = p % 2;
    desc = (col == 0 && (l % 2) == 1) ? 1 : 0;
    return p * 16 + col * 8 + desc * 4 + l;
  endfunction

  // Core stand-in: done one cycle, 3 cycles after core_start
  initial begin
    model_done = 1'b0;
    cd = 0;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) model_done = 1'b1;
      end
      if (model_en && bus.core_start) cd = 3;
    end
  end

  initial begin
    bit prev_oe;
    prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (bus.start && bus.rdy) start_cyc = ncyc;
      if (bus.load_we) load_q.push_back(int'(bus.load_addr));
      if (bus.core_start)
        core_q.push_back(int'({bus.phase_idx, bus.core_is_col, bus.core_desc, bus.core_line}));
      if (bus.output_enable) begin
        rd_q.push_back(int'(bus.rd_addr));
        if (!prev_oe) oe_first = ncyc;
        oe_last = ncyc;
      end
      prev_oe = bus.output_enable;
      if (bus.done) done_cyc = ncyc;
    end
  end

  task automatic run_load(input string tag, input bit gaps);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.en = 1'b1;
      @(posedge clk); #1 bus.en = 1'b0;
      if (gaps && (i % 4) == 1) begin
        force_done = 1'b1;
        @(posedge clk); #1 force_done = 1'b0;
      end
    end
    chk({tag, "_issue_after_load"}, int'(bus.core_start), 1);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, int'(seen), 1);
    #1;
  endtask

  task automatic finish_job(input string tag);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, int'(bus.done), 0);
    chk({tag, "_rdy_after_done"}, int'(bus.rdy), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lb, cb, rb;
    bit found;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.en = 1'b0;
    force_done = 1'b0;
    model_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", int'(bus.rdy), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_core_start", int'(bus.core_start), 0);
    chk("rst_oe", int'(bus.output_enable), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_is_col", int'(bus.core_is_col), 0);
    chk("rst_desc", int'(bus.core_desc), 0);
    chk("rst_load_addr", int'(bus.load_addr), 0);
    chk("rst_rd_addr", int'(bus.rd_addr), 0);
    chk("rst_line", int'(bus.core_line), 0);
    chk("rst_phase", int'(bus.phase_idx), 0);

    // Job A: gapped load with stray core_done in the gaps, full run
    lb = load_q.size(); cb = core_q.size(); rb = rd_q.size();
    run_load("a", 1'b1);
    wait_done("a");
    chk("a_load_count", load_q.size() - lb, 16);
    for (int j = 0; j < 16; j++)
      chk($sformatf("a_load_addr%0d", j), (load_q.size() > lb + j) ? load_q[lb + j] : -1, j);
    chk("a_core_count", core_q.size() - cb, 20);
    for (int j = 0; j < 20; j++)
      chk($sformatf("a_core%0d", j), (core_q.size() > cb + j) ? core_q[cb + j] : -1, exp_core(j));
    chk("a_rd_count", rd_q.size() - rb, 16);
    for (int j = 0; j < 16; j++)
      chk($sformatf("a_rd%0d", j), (rd_q.size() > rb + j) ? rd_q[rb + j] : -1, exp_rd[j]);
    chk("a_oe_contiguous", oe_last - oe_first, 15);
    chk("a_oe_to_done", done_cyc - oe_last, 1);
    finish_job("a");

    // Job B: reset while waiting on phase 2, line 1
    run_load("b", 1'b0);
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.phase_idx == 3'd2 && bus.core_line == 2'd1 && bus.busy &&
          !bus.core_start && !bus.output_enable) begin
        found = 1'b1;
        break;
      end
    end
    chk("b_reached_ph2_line1", int'(found), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("b_rst_rdy", int'(bus.rdy), 1);
    chk("b_rst_busy", int'(bus.busy), 0);
    chk("b_rst_phase", int'(bus.phase_idx), 0);
    chk("b_rst_line", int'(bus.core_line), 0);

    // Job C: continuous load after reset, latency check
    lb = load_q.size(); cb = core_q.size();
    run_load("c", 1'b0);
    wait_done("c");
    chk("c_load_count", load_q.size() - lb, 16);
    chk("c_first_load_addr", (load_q.size() > lb) ? load_q[lb] : -1, 0);
    chk("c_core_count", core_q.size() - cb, 20);
    chk("c_latency", done_cyc - start_cyc + 1, 114);
    finish_job("c");

    // Job D: held core_done, core_done in ISSUE, start while busy
    model_en = 1'b0;
    run_load("d", 1'b0);
    force_done = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    force_done = 1'b0;
    chk("d_line_after_hold", int'(bus.core_line), 1);
    chk("d_in_wait", int'(bus.core_start), 0);
    chk("d_phase", int'(bus.phase_idx), 0);
    bus.start = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("d_line_stable", int'(bus.core_line), 1);
    chk("d_still_busy", int'(bus.busy), 1);
    chk("d_no_reissue", int'(bus.core_start), 0);
    chk("d_no_load_we", int'(bus.load_we), 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("d_rst_rdy", int'(bus.rdy), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
